dm_preloader: RTL and testbench
===============================

# dm_preloader

Synchronous byte-stream loader that sits directly upstream of the processor's data memory and reset input. It accepts exactly `DATA_MEM_SIZE` bytes plus one checksum byte over a valid/ready stream and writes them sequentially into data memory. It holds the processor in reset throughout the load and releases reset only after the checksum verifies. It replaces the simulation-only hierarchical preload of `DataMem` with a synthesizable path usable on FPGA.

## Interface
- `MEM_SIZE`, default `DATA_MEM_SIZE`: number of data-memory bytes loaded per image; ≥ 2.
- `ADDR_W`, default `$clog2(MEM_SIZE)`: width of `dm_addr`.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle load request.
- `s_valid` in 1: stream byte valid.
- `s_data` in 8: stream byte.
- `s_ready` out 1: block accepts a byte this cycle.
- `dm_we` out 1: data-memory byte write enable.
- `dm_addr` out ADDR_W: data-memory byte address.
- `dm_wdata` out 8: data-memory write byte.
- `cpu_rst_n` out 1: processor reset, active-low; drives `RISCV_PROCESSOR.rst_n`.
- `busy` out 1: load in progress.
- `done` out 1: image loaded, checksum good, CPU running.
- `err` out 1: checksum mismatch; CPU held in reset.

## Operation
- States: IDLE, LOAD, CHECK, RELEASE, RUN, ERROR.
- A byte is accepted when `s_valid && s_ready`. `s_ready` = 1 only in LOAD and CHECK.
- **IDLE:** `cpu_rst_n`=0. `start` → LOAD. On the same edge, `byte_cnt`=0 and `sum`=0.
- **LOAD:** each accepted byte does three things:
  - Registers `dm_we`=1, `dm_addr`=`byte_cnt`, `dm_wdata`=`s_data` for the next cycle.
  - Updates `sum` ← `sum + s_data` (mod 256).
  - Updates `byte_cnt` ← `byte_cnt+1`.
- **LOAD exit:** accepting the byte at `byte_cnt`=MEM_SIZE−1 → CHECK.
- **LOAD stall:** `s_valid`=0 stalls with no write. There is no timeout.
- **CHECK:** the next accepted byte is compared with `sum`. It is never written to memory.
  - Equal → RELEASE.
  - Unequal → ERROR.
- **RELEASE:** 2-cycle counter, `cpu_rst_n` still 0. Then → RUN.
- **RUN:** `cpu_rst_n`=1, `done`=1.
- **ERROR:** `err`=1, `cpu_rst_n`=0.
- **start in RUN or ERROR:** → LOAD. Clears `done`/`err`, drops `cpu_rst_n` to 0 on the next edge, and resets `byte_cnt`/`sum`.
- **start in LOAD, CHECK or RELEASE:** ignored.
- `busy` = 1 in LOAD, CHECK, RELEASE.
- **Memory write port:** `dm_we` is high for exactly one cycle per accepted LOAD byte and is 0 in every other state. `dm_addr`/`dm_wdata` hold their last values when `dm_we`=0.
- **Mid-operation reset:** `rst` during any state → IDLE on that edge. Partial memory contents are left as-is; no rollback.

## Timing
- **Reset values:** state=IDLE, `s_ready`=0, `dm_we`=0, `dm_addr`=0, `dm_wdata`=0, `cpu_rst_n`=0, `busy`=0, `done`=0, `err`=0, `byte_cnt`=0, `sum`=0.
- `start` sampled at edge N → LOAD, `s_ready`=1 and `busy`=1 from cycle N+1.
- **Accept-to-write latency:** byte accepted at edge K → `dm_we`=1 during cycle K+1, with write committed by memory at edge K+2.
- **Back-to-back:** with `s_valid` continuously high, one byte per cycle; MEM_SIZE+1 accepting cycles.
- **Checksum to CPU release:** checksum accepted at edge C → RELEASE during cycles C+1, C+2. Then `cpu_rst_n`=1 and `done`=1 from cycle C+3. The last data write (edge C) completes before reset release.
- **Mismatch:** checksum accepted at edge C → `err`=1 from cycle C+1.
- `s_ready` is a state decode only; it never depends combinationally on `s_valid`.
- `byte_cnt` is ADDR_W+1 bits wide so that MEM_SIZE being a power of two cannot wrap before the compare.
- **Simultaneous `rst` and `start`:** `rst` wins.

## Test plan
- **Reset values:** MEM_SIZE=16. Assert `rst` 2 cycles → all outputs at reset values, `cpu_rst_n`=0. `s_valid`=1 while in IDLE → no accept, no write.
- **Good load:** `start`, stream bytes 0x01..0x10 back-to-back, then checksum 0x88.
  - 16 writes at addresses 0..15 with matching data, one cycle after each accept.
  - `busy` falls, `cpu_rst_n`=1 and `done`=1 exactly 3 cycles after checksum accept.
- **Bad checksum:** same stream with checksum 0x87 → `err`=1, `cpu_rst_n` stays 0, `done`=0, no 17th write. Then `start` plus a good stream → `err`=0, `done`=1.
- **Gapped stream:** random `s_valid` gaps (including 10-cycle gaps) over bytes 0xFF×16 with checksum 0xF0 → exactly 16 writes, no write during gaps, `done`=1.
- **Reload from RUN and ignored start:**
  - From RUN, pulse `start` → `cpu_rst_n`=0 next cycle, `done`=0, `byte_cnt` restarts at address 0.
  - `start` pulsed mid-LOAD is ignored (addresses continue).
- **Reset mid-load:** assert `rst` after 7 bytes → IDLE next cycle, `s_ready`=0, `dm_we`=0. A new `start` reloads from address 0 with `sum` cleared.

Source files
------------

// File: rtl/dm_preloader_if.sv
// dm_preloader_if
//   Bundles the byte stream feeding the preloader and the data-memory write
//   port it drives.
//
//   Stream:  s_valid, s_data[7:0] (source -> preloader), s_ready (preloader -> source)
//   Memory:  dm_we, dm_addr[ADDR_W-1:0], dm_wdata[7:0] (preloader -> data memory)
//
//   Modports:
//     master : the environment side (stream source and memory sink)
//     slave  : the preloader side
interface dm_preloader_if #(
  parameter int ADDR_W = 4
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [7:0]        dm_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, dm_we, dm_addr, dm_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, dm_we, dm_addr, dm_wdata
  );
endinterface

// File: rtl/dm_preloader.sv
// dm_preloader
//   Streams a data-memory image (MEM_SIZE bytes followed by one 8-bit additive
//   checksum byte) into the processor's data memory. The processor is held in
//   reset for the whole load and only released once the checksum matches.
//
//   Ports:
//     clk        : single clock, rising edge
//     rst        : synchronous, active-high reset
//     start      : one-cycle load request (honoured in IDLE, RUN and ERROR)
//     bus        : dm_preloader_if.slave (byte stream in, memory write port out)
//     cpu_rst_n  : processor reset, active-low; high only in RUN
//     busy       : load in progress (LOAD, CHECK, RELEASE)
//     done       : image loaded, checksum good, processor running
//     err        : checksum mismatch, processor held in reset
`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 1024
`endif

module dm_preloader #(
  parameter int MEM_SIZE = `DATA_MEM_SIZE,
  parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  dm_preloader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err
);

  // One extra bit so a power-of-two MEM_SIZE cannot wrap before the last-byte compare.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  byte_cnt, byte_cnt_next;
  logic [7:0]        sum, sum_next;
  logic              rel_cnt, rel_cnt_next;
  logic              dm_we_q, dm_we_next;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_next;
  logic [7:0]        dm_wdata_q, dm_wdata_next;
  logic              s_ready;
  logic              accept;

  // s_ready is a pure state decode so it never depends on s_valid in the same cycle.
  assign s_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign accept  = bus.s_valid && s_ready;

  assign bus.s_ready  = s_ready;
  assign bus.dm_we    = dm_we_q;
  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_wdata = dm_wdata_q;

  assign busy      = (state == ST_LOAD) || (state == ST_CHECK) || (state == ST_RELEASE);
  assign done      = (state == ST_RUN);
  assign err       = (state == ST_ERROR);
  assign cpu_rst_n = (state == ST_RUN);

  // Next-state and next-datapath logic. The memory write strobe defaults low so it
  // is only ever high for the single cycle following an accepted LOAD byte, while
  // address/data hold their last values between writes.
  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    sum_next      = sum;
    rel_cnt_next  = rel_cnt;
    dm_we_next    = 1'b0;
    dm_addr_next  = dm_addr_q;
    dm_wdata_next = dm_wdata_q;

    case (state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          state_next    = ST_LOAD;
          byte_cnt_next = '0;
          sum_next      = '0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          dm_we_next    = 1'b1;
          dm_addr_next  = byte_cnt[ADDR_W-1:0];
          dm_wdata_next = bus.s_data;
          sum_next      = sum + bus.s_data;
          byte_cnt_next = byte_cnt + CNT_W'(1);
          if (byte_cnt == LAST_IDX) begin
            state_next = ST_CHECK;
          end
        end
      end

      // The checksum byte is compared against the running sum and never written.
      ST_CHECK: begin
        if (accept) begin
          rel_cnt_next = 1'b0;
          state_next   = (bus.s_data == sum) ? ST_RELEASE : ST_ERROR;
        end
      end

      // Two cycles of extra reset hold so the final memory write lands first.
      ST_RELEASE: begin
        if (rel_cnt) begin
          state_next = ST_RUN;
        end else begin
          rel_cnt_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any simultaneous start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      sum        <= '0;
      rel_cnt    <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
    end else begin
      state      <= state_next;
      byte_cnt   <= byte_cnt_next;
      sum        <= sum_next;
      rel_cnt    <= rel_cnt_next;
      dm_we_q    <= dm_we_next;
      dm_addr_q  <= dm_addr_next;
      dm_wdata_q <= dm_wdata_next;
    end
  end

endmodule

// File: tb/tb_dm_preloader.sv
// tb_dm_preloader
//   Self-checking bench for dm_preloader with MEM_SIZE=16. Expected memory
//   writes are queued as bytes are handed over and popped by a write monitor;
//   load scenarios come from a vector table, with hand-written sequences for
//   reset behaviour and reset in the middle of a load.
module tb_dm_preloader;

  localparam int MEM_SIZE = 16;
  localparam int ADDR_W   = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_rst_n;
  logic busy;
  logic done;
  logic err;

  int total  = 0;
  int bad    = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  // pattern 0: bytes 0x01..0x10 (sum 0x88); pattern 1: 0xFF x16 (sum 0xF0)
  typedef struct {
    int         pattern;
    logic [7:0] chk;
    bit         gaps;
    bit         good;
    bit         mid_start;
  } vec_t;

  vec_t vecs[7];

  dm_preloader_if #(.ADDR_W(ADDR_W)) bus ();

  dm_preloader #(
    .MEM_SIZE(MEM_SIZE),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.dm_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.dm_addr, bus.dm_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(bus.dm_addr), 32'(mon_e.addr));
        checkOutput("wr_data", 32'(bus.dm_wdata), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Hold a byte on the stream until the handshake completes (bounded wait).
  task automatic send_byte(input logic [7:0] b, input bit is_data, input int idx);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    checkOutput($sformatf("byte%0d_accepted", idx), 32'(ok), 32'd1);
    if (ok && is_data) begin
      exp_q.push_back('{addr: ADDR_W'(idx), data: b});
    end
  endtask

  task automatic applyStimulus(input int id, input vec_t v);
    int         w0;
    int         g;
    logic [7:0] b;
    logic [7:0] last_b;
    w0     = wr_cnt;
    last_b = 8'h00;

    pulse_start();
    checkOutput($sformatf("v%0d_busy_after_start", id), 32'(busy), 32'd1);
    checkOutput($sformatf("v%0d_ready_after_start", id), 32'(bus.s_ready), 32'd1);
    checkOutput($sformatf("v%0d_cpu_rst_n_after_start", id), 32'(cpu_rst_n), 32'd0);
    checkOutput($sformatf("v%0d_done_after_start", id), 32'(done), 32'd0);
    checkOutput($sformatf("v%0d_err_after_start", id), 32'(err), 32'd0);

    for (int i = 0; i < MEM_SIZE; i++) begin
      if (v.gaps) begin
        g = (i == 5) ? 10 : int'($urandom_range(0, 3));
        if (g > 0) begin
          bus.s_valid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
      b      = (v.pattern == 0) ? 8'(i + 1) : 8'hFF;
      last_b = b;
      if (v.mid_start && i == 7) start = 1'b1;
      send_byte(b, 1'b1, i);
      start = 1'b0;
    end

    if (v.gaps) begin
      bus.s_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
    send_byte(v.chk, 1'b0, MEM_SIZE);
    bus.s_valid = 1'b0;

    if (v.good) begin
      checkOutput($sformatf("v%0d_rel1_cpu_rst_n", id), 32'(cpu_rst_n), 32'd0);
      checkOutput($sformatf("v%0d_rel1_busy", id), 32'(busy), 32'd1);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_rel2_done", id), 32'(done), 32'd0);
      checkOutput($sformatf("v%0d_rel2_busy", id), 32'(busy), 32'd1);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_run_done", id), 32'(done), 32'd1);
      checkOutput($sformatf("v%0d_run_cpu_rst_n", id), 32'(cpu_rst_n), 32'd1);
      checkOutput($sformatf("v%0d_run_busy", id), 32'(busy), 32'd0);
      checkOutput($sformatf("v%0d_run_err", id), 32'(err), 32'd0);
    end else begin
      checkOutput($sformatf("v%0d_err_set", id), 32'(err), 32'd1);
      checkOutput($sformatf("v%0d_err_busy", id), 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_err_held", id), 32'(err), 32'd1);
      checkOutput($sformatf("v%0d_err_cpu_rst_n", id), 32'(cpu_rst_n), 32'd0);
      checkOutput($sformatf("v%0d_err_done", id), 32'(done), 32'd0);
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d_write_count", id), 32'(wr_cnt - w0), 32'(MEM_SIZE));
    checkOutput($sformatf("v%0d_queue_drained", id), 32'(exp_q.size()), 32'd0);
    checkOutput($sformatf("v%0d_we_idle", id), 32'(bus.dm_we), 32'd0);
    checkOutput($sformatf("v%0d_addr_hold", id), 32'(bus.dm_addr), 32'(MEM_SIZE - 1));
    checkOutput($sformatf("v%0d_wdata_hold", id), 32'(bus.dm_wdata), 32'(last_b));
  endtask

  initial begin
    vecs[0] = '{pattern: 0, chk: 8'h88, gaps: 1'b0, good: 1'b1, mid_start: 1'b0};
    vecs[1] = '{pattern: 0, chk: 8'h87, gaps: 1'b0, good: 1'b0, mid_start: 1'b0};
    vecs[2] = '{pattern: 0, chk: 8'h88, gaps: 1'b0, good: 1'b1, mid_start: 1'b0};
    vecs[3] = '{pattern: 1, chk: 8'hF0, gaps: 1'b1, good: 1'b1, mid_start: 1'b0};
    vecs[4] = '{pattern: 1, chk: 8'h00, gaps: 1'b1, good: 1'b0, mid_start: 1'b0};
    vecs[5] = '{pattern: 0, chk: 8'h88, gaps: 1'b1, good: 1'b1, mid_start: 1'b0};
    vecs[6] = '{pattern: 0, chk: 8'h88, gaps: 1'b0, good: 1'b1, mid_start: 1'b1};

    rst         = 1'b1;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    $display("[TB] reset values");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("rst_dm_we", 32'(bus.dm_we), 32'd0);
    checkOutput("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    checkOutput("rst_dm_wdata", 32'(bus.dm_wdata), 32'd0);
    checkOutput("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);

    rst         = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_s_ready", 32'(bus.s_ready), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
    end
    bus.s_valid = 1'b0;

    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst_start_busy", 32'(busy), 32'd0);
    checkOutput("rst_start_s_ready", 32'(bus.s_ready), 32'd0);

    $display("[TB] vector table");
    for (int k = 0; k < 7; k++) begin
      applyStimulus(k, vecs[k]);
    end

    $display("[TB] reset mid-load");
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      send_byte(8'(i + 1), 1'b1, i);
    end
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_dm_we", 32'(bus.dm_we), 32'd0);
    checkOutput("midrst_dm_addr", 32'(bus.dm_addr), 32'd0);
    checkOutput("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("midrst_queue", 32'(exp_q.size()), 32'd0);
    applyStimulus(7, vecs[0]);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
